// File: rtl/color_wheel_pwm.sv
// Continuous six-sector hue wheel driving an RGB LED through per-channel PWM.
// Hue position (sector, level) advances one level per step interval while enabled.
module color_wheel_pwm #(
  parameter int PWM_BITS      = 8,
  parameter int STEP_INTERVAL = 12000,
  parameter bit INVERT        = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       dir,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [2:0] sector
);

  localparam int SW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_INTERVAL - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   FULL      = {1'b1, {PWM_BITS{1'b0}}};

  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [SW-1:0]       step_q, step_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [2:0]          hue_sec_q, hue_sec_d;
  logic                tick_s;
  logic [PWM_BITS:0]   rise_s, fall_s, duty_r_s, duty_g_s, duty_b_s;
  logic                red_q, green_q, blue_q;
  logic [2:0]          sector_q;

  // Next-state for PWM counter, step counter and hue position
  always_comb begin
    pwm_d     = pwm_q + PWM_BITS'(1);
    step_d    = step_q;
    tick_s    = 1'b0;
    level_d   = level_q;
    hue_sec_d = hue_sec_q;
    if (enable) begin
      if (step_q == STEP_LAST) begin
        step_d = '0;
        tick_s = 1'b1;
      end else begin
        step_d = step_q + SW'(1);
      end
    end else begin
      step_d = step_q;
    end
    if (tick_s) begin
      if (hue_sec_q > 3'd5) begin
        // Recover from an unreachable sector code
        hue_sec_d = 3'd0;
        level_d   = '0;
      end else if (dir) begin
        if (level_q == '0) begin
          level_d   = LEVEL_MAX;
          hue_sec_d = (hue_sec_q == 3'd0) ? 3'd5 : hue_sec_q - 3'd1;
        end else begin
          level_d = level_q - PWM_BITS'(1);
        end
      end else begin
        if (level_q == LEVEL_MAX) begin
          level_d   = '0;
          hue_sec_d = (hue_sec_q == 3'd5) ? 3'd0 : hue_sec_q + 3'd1;
        end else begin
          level_d = level_q + PWM_BITS'(1);
        end
      end
    end else begin
      level_d   = level_q;
      hue_sec_d = hue_sec_q;
    end
  end

  assign rise_s = {1'b0, level_q};
  assign fall_s = FULL - rise_s;

  // Per-sector duty table; rising channel ramps up, falling channel ramps down
  always_comb begin
    duty_r_s = '0;
    duty_g_s = '0;
    duty_b_s = '0;
    case (hue_sec_q)
      3'd0: begin duty_r_s = FULL;   duty_g_s = rise_s; duty_b_s = '0;     end
      3'd1: begin duty_r_s = fall_s; duty_g_s = FULL;   duty_b_s = '0;     end
      3'd2: begin duty_r_s = '0;     duty_g_s = FULL;   duty_b_s = rise_s; end
      3'd3: begin duty_r_s = '0;     duty_g_s = fall_s; duty_b_s = FULL;   end
      3'd4: begin duty_r_s = rise_s; duty_g_s = '0;     duty_b_s = FULL;   end
      3'd5: begin duty_r_s = FULL;   duty_g_s = '0;     duty_b_s = fall_s; end
      default: begin duty_r_s = '0;  duty_g_s = '0;     duty_b_s = '0;     end
    endcase
  end

  // State and registered pin drive; polarity is applied last, including reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q     <= '0;
      step_q    <= '0;
      level_q   <= '0;
      hue_sec_q <= 3'd0;
      red_q     <= INVERT;
      green_q   <= INVERT;
      blue_q    <= INVERT;
      sector_q  <= 3'd0;
    end else begin
      pwm_q     <= pwm_d;
      step_q    <= step_d;
      level_q   <= level_d;
      hue_sec_q <= hue_sec_d;
      red_q     <= ({1'b0, pwm_q} < duty_r_s) ^ INVERT;
      green_q   <= ({1'b0, pwm_q} < duty_g_s) ^ INVERT;
      blue_q    <= ({1'b0, pwm_q} < duty_b_s) ^ INVERT;
      sector_q  <= hue_sec_q;
    end
  end

  assign red    = red_q;
  assign green  = green_q;
  assign blue   = blue_q;
  assign sector = sector_q;

endmodule

// File: tb/tb_color_wheel_pwm.sv
// Self-checking bench for color_wheel_pwm: normal and inverted-polarity instances
// run side by side against a hue-position reference model.
module tb_color_wheel_pwm;

  localparam int F     = 4;
  localparam int SI    = 4;
  localparam int WHEEL = 6 * F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic dir = 1'b0;
  logic red, green, blue;
  logic [2:0] sector;
  logic red_n, green_n, blue_n;
  logic [2:0] sector_n;

  int checks = 0;
  int errors = 0;

  int m_pwm = 0;
  int m_step = 0;
  int m_pos = 0;
  logic [2:0] e_rgb = 3'b000;
  logic [2:0] e_sec = 3'd0;

  always #5 clk = ~clk;

  color_wheel_pwm #(.PWM_BITS(2), .STEP_INTERVAL(4), .INVERT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir),
    .red(red), .green(green), .blue(blue), .sector(sector)
  );

  color_wheel_pwm #(.PWM_BITS(2), .STEP_INTERVAL(4), .INVERT(1'b1)) u_inv (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dir(dir),
    .red(red_n), .green(green_n), .blue(blue_n), .sector(sector_n)
  );

  // Duty of channel ch (0=R,1=G,2=B) for a sector and level
  function automatic int duty(input int sec, input int lvl, input int ch);
    int d[3];
    int rise;
    int fall;
    rise = lvl;
    fall = F - lvl;
    case (sec)
      0: d = '{F, rise, 0};
      1: d = '{fall, F, 0};
      2: d = '{0, F, rise};
      3: d = '{0, fall, F};
      4: d = '{rise, 0, F};
      5: d = '{F, 0, fall};
      default: d = '{0, 0, 0};
    endcase
    return d[ch];
  endfunction

  // Advance one clock and the model; expected outputs reflect the state before the edge
  task automatic clk_step();
    int sec;
    int lvl;
    @(posedge clk);
    if (!rst_n) begin
      m_pwm = 0;
      m_step = 0;
      m_pos = 0;
      e_rgb = 3'b000;
      e_sec = 3'd0;
    end else begin
      sec = m_pos / F;
      lvl = m_pos % F;
      e_rgb = {m_pwm < duty(sec, lvl, 0), m_pwm < duty(sec, lvl, 1), m_pwm < duty(sec, lvl, 2)};
      e_sec = 3'(sec);
      m_pwm = (m_pwm + 1) % F;
      if (enable) begin
        if (m_step == SI - 1) begin
          m_step = 0;
          m_pos = dir ? (m_pos + WHEEL - 1) % WHEEL : (m_pos + 1) % WHEEL;
        end else begin
          m_step = m_step + 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      checks++;
      if ({red, green, blue, sector} !== 6'b000_000) begin
        errors++; $display("FAIL reset_hold: got %b want 000000", {red, green, blue, sector});
      end
      checks++;
      if ({red_n, green_n, blue_n, sector_n} !== 6'b111_000) begin
        errors++; $display("FAIL reset_hold_inv: got %b want 111000", {red_n, green_n, blue_n, sector_n});
      end
    end
    rst_n = 1'b1;
    #2;
    checks++;
    if ({red, green, blue, red_n, green_n, blue_n} !== 6'b000_111) begin
      errors++; $display("FAIL reset_release: got %b want 000111", {red, green, blue, red_n, green_n, blue_n});
    end
    for (int i = 0; i < 4; i++) begin
      clk_step();
      checks++;
      if ({red, green, blue, sector} !== 6'b100_000) begin
        errors++; $display("FAIL first_interval: cyc %0d got %b want 100000", i, {red, green, blue, sector});
      end
      checks++;
      if ({red_n, green_n, blue_n, sector_n} !== {~e_rgb, e_sec}) begin
        errors++; $display("FAIL first_interval_inv: got %b want %b", {red_n, green_n, blue_n, sector_n}, {~e_rgb, e_sec});
      end
    end
  endtask

  task automatic test_forward();
    int gcnt;
    gcnt = 0;
    for (int i = 0; i < 4; i++) begin
      clk_step();
      gcnt += int'(green);
      checks++;
      if (red !== 1'b1 || blue !== 1'b0) begin
        errors++; $display("FAIL fwd_l1: red %b blue %b want 1 0", red, blue);
      end
    end
    checks++;
    if (gcnt != 1) begin
      errors++; $display("FAIL fwd_green_duty: got %0d/4 want 1/4", gcnt);
    end
    for (int i = 0; i < 9; i++) clk_step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) clk_step();
      checks++;
      if ({red, green, blue, sector} !== 6'b110_001) begin
        errors++; $display("FAIL fwd_yellow: got %b want 110001", {red, green, blue, sector});
      end
    end
    for (int i = 0; i < 77; i++) begin
      clk_step();
      checks++;
      if ({red, green, blue, sector} !== {e_rgb, e_sec}) begin
        errors++; $display("FAIL fwd_model: got %b want %b", {red, green, blue, sector}, {e_rgb, e_sec});
      end
    end
    checks++;
    if ({red, green, blue, sector} !== 6'b100_000) begin
      errors++; $display("FAIL fwd_wrap: got %b want 100000", {red, green, blue, sector});
    end
  endtask

  task automatic test_reverse();
    int bcnt;
    rst_n = 1'b0; enable = 1'b1; dir = 1'b1;
    clk_step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) clk_step();
    for (int k = 1; k <= 2; k++) begin
      bcnt = 0;
      for (int i = 0; i < 4; i++) begin
        clk_step();
        bcnt += int'(blue);
        checks++;
        if ({red, green, sector} !== 5'b10_101) begin
          errors++; $display("FAIL rev_sector5: got %b want 10101", {red, green, sector});
        end
      end
      checks++;
      if (bcnt != k) begin
        errors++; $display("FAIL rev_blue_duty: got %0d/4 want %0d/4", bcnt, k);
      end
    end
  endtask

  task automatic test_freeze();
    int bcnt;
    rst_n = 1'b0; enable = 1'b1; dir = 1'b0;
    clk_step();
    rst_n = 1'b1;
    for (int i = 0; i < 38; i++) clk_step();
    enable = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      bcnt += int'(blue);
      checks++;
      if ({red, green, sector} !== 5'b01_010) begin
        errors++; $display("FAIL freeze_hold: got %b want 01010", {red, green, sector});
      end
    end
    checks++;
    if (bcnt != 5) begin
      errors++; $display("FAIL freeze_pwm: blue high %0d of 20 want 5", bcnt);
    end
    enable = 1'b1;
    for (int i = 0; i < 2; i++) clk_step();
    bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      clk_step();
      bcnt += int'(blue);
    end
    checks++;
    if (bcnt != 2) begin
      errors++; $display("FAIL resume_partial: blue high %0d/4 want 2/4", bcnt);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; enable = 1'b1; dir = 1'b0;
    clk_step();
    rst_n = 1'b1;
    for (int i = 0; i < 66; i++) clk_step();
    checks++;
    if (sector !== 3'd4) begin
      errors++; $display("FAIL mid_setup: sector %0d want 4", sector);
    end
    rst_n = 1'b0;
    clk_step();
    checks++;
    if ({red, green, blue, sector, red_n, green_n, blue_n} !== 9'b000_000_111) begin
      errors++; $display("FAIL mid_reset: got %b want 000000111", {red, green, blue, sector, red_n, green_n, blue_n});
    end
    rst_n = 1'b1;
    clk_step();
    checks++;
    if ({red, green, blue, sector} !== 6'b100_000) begin
      errors++; $display("FAIL mid_resume: got %b want 100000", {red, green, blue, sector});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      rst_n = ($urandom_range(0, 149) != 0);
      clk_step();
      checks++;
      if ({red, green, blue, sector} !== {e_rgb, e_sec}) begin
        errors++; $display("FAIL rand_model: cyc %0d got %b want %b", i, {red, green, blue, sector}, {e_rgb, e_sec});
      end
      checks++;
      if ({red_n, green_n, blue_n, sector_n} !== {~e_rgb, e_sec}) begin
        errors++; $display("FAIL rand_model_inv: cyc %0d got %b want %b", i, {red_n, green_n, blue_n, sector_n}, {~e_rgb, e_sec});
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
